// File: rtl/fir_out_monitor.sv
// FIR output monitor: rounds/saturates the wide FIR stream to OUT_WIDTH bits and
// keeps overflow/peak statistics plus windowed overflow counts.
//
// state     | meaning
// S_IDLE    | waiting for win_start
// S_MEASURE | counting stage-2 valid samples and their saturations
// S_REPORT  | one cycle: win_done high, win_ovf_count freshly loaded
module fir_out_monitor #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int WINDOW_LEN = 48000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 clr_stats,
  input  logic                 win_start,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 sat_flag,
  output logic                 ovf_sticky,
  output logic [15:0]          ovf_count,
  output logic [IN_WIDTH-1:0]  peak_mag,
  output logic                 win_busy,
  output logic                 win_done,
  output logic [15:0]          win_ovf_count
);

  localparam int SW = IN_WIDTH + 1;
  localparam int CW = $clog2(WINDOW_LEN + 1);
  localparam logic signed [SW-1:0] RND   = SW'(1) <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] R_MAX = SW'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] R_MIN = ~R_MAX;
  localparam logic [OUT_WIDTH-1:0] O_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] O_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]        WIN_LAST = CW'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_REPORT} state_t;

  state_t                 state_q;
  logic                   v1_q;
  logic signed [SW-1:0]   r1_q;
  logic [CW-1:0]          win_cnt_q;
  logic [15:0]            win_acc_q;

  logic signed [SW-1:0]   in_ext;
  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   r_d;
  logic [IN_WIDTH-1:0]    mag;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [OUT_WIDTH-1:0]   data_d;
  logic [15:0]            win_acc_d;

  // One extra bit of headroom keeps the rounding add from wrapping near full scale.
  always_comb begin
    in_ext = {in_data[IN_WIDTH-1], in_data};
    sum    = in_ext + RND;
    r_d    = sum >>> SHIFT;
    mag    = in_data[IN_WIDTH-1] ? (~in_data + IN_WIDTH'(1)) : in_data;
    sat_hi = r1_q > R_MAX;
    sat_lo = r1_q < R_MIN;
    data_d = sat_hi ? O_MAX : (sat_lo ? O_MIN : r1_q[OUT_WIDTH-1:0]);
    win_acc_d = win_acc_q;
    if (out_valid && sat_flag && (win_acc_q != 16'hFFFF)) win_acc_d = win_acc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      r1_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      v1_q      <= in_valid;
      out_valid <= v1_q;
      if (in_valid) r1_q <= r_d;
      if (v1_q) begin
        out_data <= data_d;
        sat_flag <= sat_hi | sat_lo;
      end
    end
  end

  // A clear wins over a same-cycle update, so that sample never reaches the stats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
      peak_mag   <= '0;
    end else if (clr_stats) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
      peak_mag   <= '0;
    end else begin
      if (in_valid && (mag > peak_mag)) peak_mag <= mag;
      if (out_valid && sat_flag) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      win_cnt_q     <= '0;
      win_acc_q     <= '0;
      win_busy      <= 1'b0;
      win_done      <= 1'b0;
      win_ovf_count <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          win_done <= 1'b0;
          if (win_start) begin
            state_q   <= S_MEASURE;
            win_cnt_q <= WIN_LAST;
            win_acc_q <= '0;
            win_busy  <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (out_valid) begin
            win_acc_q <= win_acc_d;
            if (win_cnt_q == '0) begin
              state_q       <= S_REPORT;
              win_busy      <= 1'b0;
              win_done      <= 1'b1;
              win_ovf_count <= win_acc_d;
            end else begin
              win_cnt_q <= win_cnt_q - CW'(1);
            end
          end
        end
        S_REPORT: begin
          state_q  <= S_IDLE;
          win_done <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          win_busy <= 1'b0;
          win_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_monitor.sv
// Directed bench for fir_out_monitor: scoreboard on the sample path plus
// targeted checks of statistics, window FSM and reset behaviour.
module tb_fir_out_monitor;
  localparam int WL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clr_stats;
  logic        win_start;
  logic        out_valid;
  logic [15:0] out_data;
  logic        sat_flag;
  logic        ovf_sticky;
  logic [15:0] ovf_count;
  logic [31:0] peak_mag;
  logic        win_busy;
  logic        win_done;
  logic [15:0] win_ovf_count;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb_q[$];

  fir_out_monitor #(.IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(15), .WINDOW_LEN(WL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_stats(clr_stats), .win_start(win_start), .out_valid(out_valid),
    .out_data(out_data), .sat_flag(sat_flag), .ovf_sticky(ovf_sticky),
    .ovf_count(ovf_count), .peak_mag(peak_mag), .win_busy(win_busy),
    .win_done(win_done), .win_ovf_count(win_ovf_count)
  );

  always #5 clk = ~clk;

  // Reference: round half up by adding 2^14, floor-divide by 2^15, then clamp.
  function automatic logic [16:0] model(input logic [31:0] d);
    longint v;
    longint r;
    v = longint'(signed'(d));
    r = (v + 64'sd16384) >>> 15;
    if (r > 64'sd32767) return {1'b1, 16'h7FFF};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [16:0] e;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e[15:0]));
        chk("sat_flag", 64'(sat_flag), 64'(e[16]));
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic clr, input logic ws);
    in_valid  = v;
    in_data   = d;
    clr_stats = clr;
    win_start = ws;
    if (v) sb_q.push_back(model(d));
    tick();
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    win_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(output int pulses, output logic [15:0] woc);
    pulses = 0;
    woc = '0;
    repeat (30) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      if (win_done === 1'b1) begin
        pulses++;
        woc = win_ovf_count;
      end
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, "_out_data"}, 64'(out_data), 64'd0);
    chk({pfx, "_sat_flag"}, 64'(sat_flag), 64'd0);
    chk({pfx, "_ovf_sticky"}, 64'(ovf_sticky), 64'd0);
    chk({pfx, "_ovf_count"}, 64'(ovf_count), 64'd0);
    chk({pfx, "_peak_mag"}, 64'(peak_mag), 64'd0);
    chk({pfx, "_win_busy"}, 64'(win_busy), 64'd0);
    chk({pfx, "_win_done"}, 64'(win_done), 64'd0);
    chk({pfx, "_win_ovf_count"}, 64'(win_ovf_count), 64'd0);
  endtask

  initial begin
    int p;
    int dn;
    logic [15:0] w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_stats = 1'b0; win_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Rounding and two-cycle latency
    step(1'b1, 32'h0000_4000, 1'b0, 1'b0);
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lat_cycle2", 64'(out_valid), 64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("valid_drop", 64'(out_valid), 64'd0);
    idle(2);
    chk("hold_data", 64'(out_data), 64'd1);
    step(1'b1, 32'h0000_3FFF, 1'b0, 1'b0);
    idle(3);
    chk("peak_small", 64'(peak_mag), 64'h4000);

    // Positive edge of the output range
    step(1'b1, 32'h3FFF_8000, 1'b0, 1'b0);
    step(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    idle(3);
    chk("pos_sticky", 64'(ovf_sticky), 64'd1);
    chk("pos_count", 64'(ovf_count), 64'd1);

    // Negative edge, including the most negative input
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0);
    step(1'b1, 32'hBFFF_0000, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    idle(3);
    chk("neg_peak", 64'(peak_mag), 64'h8000_0000);
    chk("neg_count", 64'(ovf_count), 64'd3);
    chk("hold_sat", 64'(sat_flag), 64'd1);

    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("clr_count", 64'(ovf_count), 64'd0);
    chk("clr_sticky", 64'(ovf_sticky), 64'd0);
    chk("clr_peak", 64'(peak_mag), 64'd0);

    // Window of 8 with 3 saturations (last sample saturates), extra win_start ignored
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("w1_busy", 64'(win_busy), 64'd1);
    for (int i = 0; i < WL; i++)
      step(1'b1, (i == 1 || i == 4 || i == 7) ? 32'h4000_0000 : 32'(32'h1000 * (i + 1)),
           1'b0, (i == 3) ? 1'b1 : 1'b0);
    wait_done(p, w);
    chk("w1_done_pulses", 64'(p), 64'd1);
    chk("w1_ovf_count", 64'(w), 64'd3);
    chk("w1_busy_after", 64'(win_busy), 64'd0);
    chk("w1_stat_count", 64'(ovf_count), 64'd3);

    // clr_stats coincident with a saturating stage-2 output, inside a window
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    chk("clr_align_sat", 64'(sat_flag), 64'd1);
    step(1'b1, 32'h4000_0000, 1'b1, 1'b0);
    chk("clrsat_count", 64'(ovf_count), 64'd0);
    chk("clrsat_sticky", 64'(ovf_sticky), 64'd0);
    chk("clrsat_busy", 64'(win_busy), 64'd1);
    repeat (5) step(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    wait_done(p, w);
    chk("w2_done_pulses", 64'(p), 64'd1);
    chk("w2_ovf_count", 64'(w), 64'd2);
    chk("w2_stat_count", 64'(ovf_count), 64'd1);

    // Continuous full-scale input drives ovf_count into its ceiling
    for (int i = 0; i < 70000; i++) step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    idle(3);
    chk("long_count", 64'(ovf_count), 64'hFFFF);
    chk("long_sticky", 64'(ovf_sticky), 64'd1);
    chk("long_peak", 64'(peak_mag), 64'h7FFF_FFFF);
    chk("win_ovf_hold", 64'(win_ovf_count), 64'd2);

    // Reset in the middle of a window
    step(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    chk("pre_rst_busy", 64'(win_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    sb_q.delete();
    idle(2);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      if (win_done === 1'b1) dn++;
    end
    chk("no_done_after_rst", 64'(dn), 64'd0);
    chk("busy_after_rst", 64'(win_busy), 64'd0);

    // First post-reset sample
    step(1'b1, 32'h0001_2345, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    idle(2);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_monitor.md
FIR_OUT_MONITOR -- requirements
Module: fir_out_monitor

Consumes the 32-bit signed FIR output stream. Rounds and saturates it to 16 bits, flags overflow, and keeps overflow/peak statistics over a measurement window.

Interface
REQ-001 Parameter IN_WIDTH, default 32, input sample width (signed).
REQ-002 Parameter OUT_WIDTH, default 16, output sample width (signed).
REQ-003 Parameter SHIFT, default 15, right-shift applied before saturation.
REQ-004 Parameter WINDOW_LEN, default 48000, valid samples per measurement window (>=1).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  in_data qualifier.
REQ-008 in_data  in  IN_WIDTH  signed FIR output sample.
REQ-009 clr_stats  in  1  single-cycle pulse; clears running statistics.
REQ-010 win_start  in  1  single-cycle pulse; starts a measurement window.
REQ-011 out_valid  out  1  out_data qualifier.
REQ-012 out_data  out  OUT_WIDTH  rounded, saturated sample.
REQ-013 sat_flag  out  1  out_data was clipped; valid when out_valid=1.
REQ-014 ovf_sticky  out  1  set by any saturation since the last clear.
REQ-015 ovf_count  out  16  saturations since the last clear; holds at 0xFFFF, no wrap.
REQ-016 peak_mag  out  IN_WIDTH  largest |in_data| since the last clear, unsigned.
REQ-017 win_busy  out  1  window FSM is in MEASURE.
REQ-018 win_done  out  1  one-cycle pulse when a window completes.
REQ-019 win_ovf_count  out  16  saturation count of the last completed window, saturating.

Function
REQ-020 Datapath shall be a 2-stage pipeline.
- Stage 1: r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in IN_WIDTH+1 bits so the rounding add cannot wrap.
- Stage 2: saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-021 out_valid shall equal in_valid delayed by exactly 2 cycles.
- There is no backpressure.
- in_valid may be asserted on every cycle.
REQ-022 sat_flag shall be 1 iff r lies outside the output range; it is registered alongside out_data.
REQ-023 While out_valid=0, out_data and sat_flag shall hold their previous values.
REQ-024 Statistics update on the stage-2 output whenever out_valid=1:
- ovf_sticky is set when sat_flag=1.
- ovf_count increments when sat_flag=1.
REQ-025 peak_mag shall update in stage 1 from |in_data|. |-2^(IN_WIDTH-1)| is represented exactly as 2^(IN_WIDTH-1).
REQ-026 clr_stats shall zero ovf_sticky, ovf_count and peak_mag on the next edge. It has priority over a same-cycle update, so that sample is dropped from the statistics.
REQ-027 Window FSM states and transitions:
- IDLE -> MEASURE on win_start; the window counter and window overflow accumulator are zeroed.
- MEASURE counts stage-2 valid samples; it -> REPORT in the cycle after the WINDOW_LEN-th sample is counted.
- REPORT -> IDLE after exactly one cycle.
REQ-028 In REPORT:
- win_done=1.
- win_ovf_count loads the window accumulator, including a saturation on the final sample.
- win_ovf_count holds until the next REPORT.
REQ-029 win_start shall be ignored in MEASURE and in REPORT.
REQ-030 Samples already in the pipeline when win_start arrives shall be counted if they exit stage 2 while in MEASURE.
REQ-031 clr_stats shall not affect the window FSM or the window accumulator.
REQ-032 The window accumulator shall saturate at 0xFFFF.

Reset
REQ-033 On rst, asynchronously:
- pipeline valids = 0
- out_valid = 0, out_data = 0, sat_flag = 0
- ovf_sticky = 0, ovf_count = 0, peak_mag = 0
- win_busy = 0, win_done = 0, win_ovf_count = 0
- FSM = IDLE, window counter and accumulator = 0
REQ-034 Reset during MEASURE shall abort the window without asserting win_done.
REQ-035 The first valid output after reset release shall reflect only post-reset inputs.

Verification
REQ-036 Rounding, single-sample:
- in_data 0x00004000 -> out_data 1, sat_flag 0, two cycles later.
- in_data 0x00003FFF -> out_data 0, sat_flag 0, two cycles later.
REQ-037 Positive edge: in_data 0x3FFF8000 -> out_data 0x7FFF, sat 0; in_data 0x40000000 -> 0x7FFF, sat 1, ovf_sticky 1, ovf_count 1.
REQ-038 Negative edge: in_data 0xC0000000 -> 0x8000, sat 0; in_data 0xBFFF0000 -> 0x8000, sat 1; in_data 0x80000000 -> 0x8000, sat 1, peak_mag 0x80000000.
REQ-039 Window, WINDOW_LEN=8: win_start, then 8 back-to-back valids with 3 saturating inputs.
- win_done pulses once; win_ovf_count=3; win_busy=0 afterwards.
- A second win_start during MEASURE changes nothing.
REQ-040 clr_stats in the same cycle as a saturating stage-2 output -> ovf_count=0 and ovf_sticky=0 next cycle; an in-progress window is unaffected.
REQ-041 Continuous max input (in_data 0x7FFFFFFF, 70000 valids) -> ovf_count holds at 0xFFFF; rst asserted mid-window -> all outputs 0 immediately, with no win_done.
